// File: rtl/basic_comp_pkg.sv
// Shared word/nibble sizing for the basic-computer datapath, plus the
// second-level carry-lookahead helper used by the adder.
package basic_comp_pkg;

  localparam int WORD_W   = 16;
  localparam int NIBBLE_W = 4;
  localparam int SLICES   = WORD_W / NIBBLE_W;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [SLICES-1:0] slice_vec_t;

  // Carry into slice idx from group P/G alone (carry into slice 0 is 0), in
  // flattened sum-of-products form so no slice waits on another's carry.
  function automatic logic carry_into(input slice_vec_t grp_p,
                                      input slice_vec_t grp_g,
                                      input int unsigned idx);
    logic c;
    logic term;
    c    = 1'b0;
    term = 1'b0;
    for (int unsigned j = 0; j < SLICES; j++) begin
      if (j < idx) begin
        term = grp_g[j];
        for (int unsigned k = 0; k < SLICES; k++) begin
          if ((k > j) && (k < idx)) begin
            term = term & grp_p[k];
          end else begin
            term = term;
          end
        end
        c = c | term;
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/four_bit_cla.sv
// 4-bit carry-lookahead slice: sum, carry-out and group propagate/generate
// for the next lookahead level.
module four_bit_cla
  import basic_comp_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout,
  output logic                grp_p,
  output logic                grp_g
);

  logic [NIBBLE_W-1:0] p_s;
  logic [NIBBLE_W-1:0] g_s;
  logic [NIBBLE_W-1:0] c_s;

  assign p_s = a ^ b;
  assign g_s = a & b;

  assign c_s[0] = cin;
  assign c_s[1] = g_s[0] | (p_s[0] & cin);
  assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
  assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & cin);

  assign grp_g = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
               | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
  assign grp_p = &p_s;
  assign cout  = grp_g | (grp_p & cin);

  assign s = p_s ^ c_s;

endmodule

// File: rtl/sixteen_bit_adder.sv
// Unsigned 16-bit adder built from 4-bit CLA slices and a second lookahead
// level, with a combinational result and a one-cycle registered copy.
module sixteen_bit_adder
  import basic_comp_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sixteenbitinput1,
  input  logic [WIDTH-1:0] sixteenbitinput2,
  output logic [WIDTH-1:0] sixteenbitsum,
  output logic             sixteenbitcarry_out,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q
);

  localparam int N = WIDTH / NIBBLE_W;

  slice_vec_t     grp_p_s;
  slice_vec_t     grp_g_s;
  logic [N:0]     carry_s;
  // Slice carry-outs duplicate the lookahead carries and are left unused.
  logic [N-1:0]   cout_unused_s;

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_slice
      four_bit_cla u_cla (
        .a     (sixteenbitinput1[i*NIBBLE_W +: NIBBLE_W]),
        .b     (sixteenbitinput2[i*NIBBLE_W +: NIBBLE_W]),
        .cin   (carry_s[i]),
        .s     (sixteenbitsum[i*NIBBLE_W +: NIBBLE_W]),
        .cout  (cout_unused_s[i]),
        .grp_p (grp_p_s[i]),
        .grp_g (grp_g_s[i])
      );
    end
  endgenerate

  // Second-level lookahead: every slice carry straight from group P/G.
  always_comb begin
    carry_s = '0;
    for (int unsigned k = 0; k <= N; k++) begin
      carry_s[k] = carry_into(grp_p_s, grp_g_s, k);
    end
  end

  assign sixteenbitcarry_out = carry_s[N];

  // Pipeline register for consumers that want the result one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sixteenbitsum;
      carry_q <= sixteenbitcarry_out;
    end
  end

endmodule

// File: tb/tb_sixteen_bit_adder.sv
// Self-checking bench for sixteen_bit_adder: directed table, reset corner
// cases, and randomized vectors against a 17-bit arithmetic reference.
module tb_sixteen_bit_adder;

  logic        clk;
  logic        rst;
  logic [15:0] in1;
  logic [15:0] in2;
  logic [15:0] sum;
  logic        cout;
  logic [15:0] sum_q;
  logic        carry_q;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        carry;
  } vec_t;

  vec_t tbl[8];

  sixteen_bit_adder dut (
    .clk                 (clk),
    .rst                 (rst),
    .sixteenbitinput1    (in1),
    .sixteenbitinput2    (in2),
    .sixteenbitsum       (sum),
    .sixteenbitcarry_out (cout),
    .sum_q               (sum_q),
    .carry_q             (carry_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%05h required=%05h", name, act, exp);
    end
  endtask

  logic [16:0] prev_exp;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    tbl[0] = '{16'h0000, 16'h0000, 16'h0000, 1'b0};
    tbl[1] = '{16'h00FF, 16'h0001, 16'h0100, 1'b0};
    tbl[2] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    tbl[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
    tbl[4] = '{16'h1234, 16'h4321, 16'h5555, 1'b0};
    tbl[5] = '{16'h000F, 16'h0001, 16'h0010, 1'b0};
    tbl[6] = '{16'h0FFF, 16'h0001, 16'h1000, 1'b0};
    tbl[7] = '{16'h7FFF, 16'h8001, 16'h0000, 1'b1};

    // Reset state of the registered path.
    rst = 1'b1;
    in1 = 16'h0000;
    in2 = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {carry_q, sum_q}, 17'h00000);

    @(negedge clk);
    rst = 1'b0;

    // Directed table: combinational now, registered one edge later.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in1 = tbl[i].a;
      in2 = tbl[i].b;
      #1;
      check($sformatf("tbl%0d_comb", i), {cout, sum}, {tbl[i].carry, tbl[i].sum});
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_reg", i), {carry_q, sum_q}, {tbl[i].carry, tbl[i].sum});
    end

    // Reset held 2 cycles with 8000+8000, asserted alongside a new in-flight value.
    @(negedge clk);
    in1 = 16'h8000;
    in2 = 16'h8000;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_edge%0d_reg", i), {carry_q, sum_q}, 17'h00000);
      check($sformatf("rst_edge%0d_comb", i), {cout, sum}, 17'h10000);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release_reg", {carry_q, sum_q}, 17'h10000);

    // Randomized vectors, one per clock, registered result vs previous vector.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("rnd%0d_reg", i - 1), {carry_q, sum_q}, prev_exp);
      end
      in1 = 16'($urandom);
      in2 = 16'($urandom);
      #1;
      prev_exp = ref_add(in1, in2);
      check($sformatf("rnd%0d_comb", i), {cout, sum}, prev_exp);
    end
    @(negedge clk);
    check("rnd_last_reg", {carry_q, sum_q}, prev_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
